// File: rtl/sabr_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sabr_accum_pkg
//  Desc     : Shared types and width helpers for the SABR product accumulator.
//  Revision : 1.0  initial release
// ============================================================================
package sabr_accum_pkg;

    // Batch controller states: gather products, fold in the last one, present.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a rounded product: the dropped fraction is gone, but the
    // half-LSB bias can carry one bit above the original MSB.
    function automatic int rnd_width(input int prod_w, input int shift);
        return prod_w - shift + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sabr_valid_delay.sv
`default_nettype none
// ============================================================================
//  Module   : sabr_valid_delay
//  Desc     : Valid shift line that tracks which multiplier pipeline slots
//             hold real products; advances only with the multiplier's ce.
//  Revision : 1.0  initial release
// ============================================================================
module sabr_valid_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_din,
    output logic o_tail
);

    generate
        if (DEPTH == 1) begin : g_single
            logic r_line;

            // Single-stage line: capture the issue flag when the multiplier advances.
            always_ff @(posedge clk) begin
                if (rst)
                    r_line <= 1'b0;
                else if (i_en)
                    r_line <= i_din;
            end

            assign o_tail = r_line;
        end else begin : g_chain
            logic [DEPTH-1:0] r_line;

            // Shift the issue flag through the line in step with the multiplier stages.
            always_ff @(posedge clk) begin
                if (rst)
                    r_line <= '0;
                else if (i_en)
                    r_line <= {r_line[DEPTH-2:0], i_din};
            end

            assign o_tail = r_line[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sabr_prod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : sabr_prod_accum
//  Desc     : Rounds each multiplier product, sums NUM_SAMPLES of them with
//             saturation, and hands the batch sum out on a valid/ready port
//             while holding the multiplier frozen through mul_ce.
//  Revision : 1.0  initial release
// ============================================================================
module sabr_prod_accum
    import sabr_accum_pkg::*;
#(
    parameter int PROD_W      = 89,
    parameter int MUL_LAT     = 4,
    parameter int SHIFT       = 32,
    parameter int ACC_W       = 64,
    parameter int NUM_SAMPLES = 1024,
    parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              issue_valid,
    output logic              mul_ce,
    input  logic [PROD_W-1:0] mul_dout,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sat_o,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int              c_RND_W = rnd_width(PROD_W, SHIFT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_SAMPLES - 1);

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_rnd;
    logic              r_rnd_vld;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_tail;
    logic              w_take;
    logic [PROD_W:0]   w_biased;
    logic [c_RND_W-1:0] w_rnd;
    logic [ACC_W-1:0]  w_rnd_clamp;
    logic              w_rnd_ovf;
    logic [ACC_W:0]    w_acc_sum;
    logic [ACC_W-1:0]  w_acc_next;

    // The multiplier only advances while we are collecting; FLUSH and DONE
    // freeze it so in-flight products roll into the next batch intact.
    assign mul_ce = ce & (r_state == ACCUM);
    assign w_take = mul_ce & w_tail;

    sabr_valid_delay #(
        .DEPTH (MUL_LAT)
    ) u_valid_delay (
        .clk    (clk),
        .rst    (reset),
        .i_en   (mul_ce),
        .i_din  (issue_valid),
        .o_tail (w_tail)
    );

    // Round half-up: add half an output LSB, then drop the fraction bits.
    generate
        if (SHIFT > 0) begin : g_round
            assign w_biased = {1'b0, mul_dout} + ((PROD_W + 1)'(1) << (SHIFT - 1));
            assign w_rnd    = c_RND_W'(w_biased >> SHIFT);
        end else begin : g_no_round
            assign w_biased = {1'b0, mul_dout};
            assign w_rnd    = w_biased;
        end
    endgenerate

    // Clamp a rounded product that cannot fit the accumulator width.
    generate
        if (c_RND_W > ACC_W) begin : g_clamp
            assign w_rnd_ovf   = |w_rnd[c_RND_W-1:ACC_W];
            assign w_rnd_clamp = w_rnd_ovf ? '1 : w_rnd[ACC_W-1:0];
        end else begin : g_no_clamp
            assign w_rnd_ovf   = 1'b0;
            assign w_rnd_clamp = ACC_W'(w_rnd);
        end
    endgenerate

    // One extra bit catches the carry; a saturated acc stays all-ones since
    // any further non-zero addend carries again.
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_rnd};
    assign w_acc_next = w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];

    // Batch controller, round register, accumulator, counter and result port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_rnd     <= '0;
            r_rnd_vld <= 1'b0;
            r_cnt     <= '0;
            sum_o     <= '0;
            sat_o     <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            r_rnd_vld <= w_take;
            if (w_take) begin
                r_rnd <= w_rnd_clamp;
                r_cnt <= r_cnt + 1'b1;
                if (w_rnd_ovf)
                    sat_o <= 1'b1;
            end
            if (r_rnd_vld) begin
                r_acc <= w_acc_next;
                if (w_acc_sum[ACC_W])
                    sat_o <= 1'b1;
            end
            case (r_state)
                ACCUM: begin
                    if (w_take && (r_cnt == c_LAST))
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    // The last rounded product lands in acc this cycle.
                    r_state   <= DONE;
                    sum_o     <= w_acc_next;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= ACCUM;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        sat_o     <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sabr_prod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sabr_prod_accum
//  Desc     : Two accumulator configurations fed by one modelled multiplier
//             pipeline, compared against a batch-level reference every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sabr_prod_accum;

    localparam int PW = 89;
    localparam int N  = 4;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic          issue_valid;
    logic          out_ready;
    logic [PW-1:0] prod;
    logic [PW-1:0] mul_dout;
    logic          mul_ce_a, mul_ce_b;
    logic [7:0]    sum_a;
    logic [63:0]   sum_b;
    logic          sat_a, sat_b, ov_a, ov_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    // Reference state: issued product list, acceptance count and batch phase.
    logic [PW-1:0] q[$];
    logic [PW-1:0] pipe_d [LAT];
    logic [LAT-1:0] pv = '0;
    int            n_acc = 0;
    int            phase = 0;   // 0 collecting, 1 last product folding in, 2 result held
    logic          exp_ov = 1'b0;
    logic [63:0]   exp_sum_a = '0, exp_sum_b = '0;
    logic          exp_sat_a = 1'b0, exp_sat_b = 1'b0;

    always #5 clk = ~clk;

    assign mul_dout = pipe_d[LAT-1];

    sabr_prod_accum #(
        .PROD_W(PW), .MUL_LAT(LAT), .SHIFT(0), .ACC_W(8), .NUM_SAMPLES(N)
    ) u_dut_a (
        .clk(clk), .reset(reset), .ce(ce), .issue_valid(issue_valid),
        .mul_ce(mul_ce_a), .mul_dout(mul_dout), .sum_o(sum_a), .sat_o(sat_a),
        .out_valid(ov_a), .out_ready(out_ready)
    );

    sabr_prod_accum #(
        .PROD_W(PW), .MUL_LAT(LAT), .SHIFT(4), .ACC_W(64), .NUM_SAMPLES(N)
    ) u_dut_b (
        .clk(clk), .reset(reset), .ce(ce), .issue_valid(issue_valid),
        .mul_ce(mul_ce_b), .mul_dout(mul_dout), .sum_o(sum_b), .sat_o(sat_b),
        .out_valid(ov_b), .out_ready(out_ready)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Round half-up, clamp to the accumulator range, then saturating add.
    function automatic void add_rounded(input logic [PW-1:0] p, input int sh, input int aw,
                                        inout logic [127:0] s, inout logic st);
        logic [127:0] mx, r;
        mx = (128'd1 << aw) - 128'd1;
        r  = {39'd0, p};
        if (sh > 0) r = (r + (128'd1 << (sh - 1))) >> sh;
        if (r > mx) begin r = mx; st = 1'b1; end
        s = s + r;
        if (s > mx) begin s = mx; st = 1'b1; end
    endfunction

    // Reference: multiplier pipeline plus batch bookkeeping per enabled edge.
    always @(posedge clk) begin : ref_model
        logic mce, take;
        logic [127:0] sa, sb;
        logic sta, stb, pk;
        logic [PW-1:0] p;
        if (reset) begin
            q.delete();
            pv     = '0;
            n_acc  = 0;
            phase  = 0;
            exp_ov = 1'b0;
        end else if (ce) begin
            mce  = (phase == 0);
            take = mce && pv[LAT-1];
            if (mce) begin
                pv = {pv[LAT-2:0], issue_valid};
                if (issue_valid) q.push_back(prod);
                pipe_d[0] <= prod;
                for (int k = 1; k < LAT; k++) pipe_d[k] <= pipe_d[k-1];
            end
            case (phase)
                0: if (take) begin
                    n_acc++;
                    if (n_acc == N) phase = 1;
                end
                1: begin
                    sa = '0; sb = '0; sta = 1'b0; stb = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        pk = (q.size() > 0);
                        p  = pk ? q.pop_front() : '0;
                        add_rounded(p, 0, 8, sa, sta);
                        add_rounded(p, 4, 64, sb, stb);
                    end
                    exp_sum_a = sa[63:0]; exp_sat_a = sta;
                    exp_sum_b = sb[63:0]; exp_sat_b = stb;
                    exp_ov = 1'b1;
                    phase  = 2;
                end
                default: if (out_ready) begin
                    phase  = 0;
                    n_acc  = 0;
                    exp_ov = 1'b0;
                end
            endcase
        end
    end

    // Every-cycle comparison of both configurations against the reference.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mul_ce_a", {63'd0, mul_ce_a}, {63'd0, ce && (phase == 0)});
            chk("mul_ce_b", {63'd0, mul_ce_b}, {63'd0, ce && (phase == 0)});
            chk("out_valid_a", {63'd0, ov_a}, {63'd0, exp_ov});
            chk("out_valid_b", {63'd0, ov_b}, {63'd0, exp_ov});
            if (exp_ov) begin
                chk("sum_a", {56'd0, sum_a}, exp_sum_a);
                chk("sat_a", {63'd0, sat_a}, {63'd0, exp_sat_a});
                chk("sum_b", sum_b, exp_sum_b);
                chk("sat_b", {63'd0, sat_b}, {63'd0, exp_sat_b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [PW-1:0] p);
        issue_valid = 1'b1;
        prod        = p;
        tick();
        issue_valid = 1'b0;
        prod        = PW'({$urandom, $urandom, $urandom});
    endtask

    task automatic wait_ov(input string nm);
        int k;
        k = 0;
        while (!ov_a && k < 60) begin tick(); k++; end
        n_cmp++;
        if (!ov_a) begin
            n_bad++;
            $display("FAIL %s timeout: out_valid=%0b, expected 1", nm, ov_a);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [PW-1:0] rand_prod();
        case ($urandom % 4)
            0:       return PW'($urandom % 64);
            1:       return PW'($urandom % 4096);
            2:       return PW'({$urandom, $urandom}) << ($urandom % 16);
            default: return PW'({$urandom, $urandom, $urandom});
        endcase
    endfunction

    initial begin
        logic [PW-1:0] t5 [4];
        int idx;
        t5 = '{89'd9, 89'd8, 89'd7, 89'd6};
        reset = 1'b1; ce = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; prod = '0;
        tick(); tick();
        chk_on = 1'b1;
        chk("reset_sum_a", {56'd0, sum_a}, 64'd0);
        chk("reset_sum_b", sum_b, 64'd0);
        chk("reset_sat_a", {63'd0, sat_a}, 64'd0);
        chk("reset_ov_a", {63'd0, ov_a}, 64'd0);
        reset = 1'b0;

        // Plain sum, no rounding in A; rounding in B.
        issue(89'd10); issue(89'd20); issue(89'd30); issue(89'd40);
        wait_ov("t1");
        chk("t1_sum_a", {56'd0, sum_a}, 64'd100);
        chk("t1_sat_a", {63'd0, sat_a}, 64'd0);
        chk("t1_sum_b", sum_b, 64'd7);
        handshake();

        // Round half-up boundaries.
        issue(89'h18); issue(89'h17); issue(89'h08); issue(89'h10);
        wait_ov("t2");
        chk("t2_sum_b", sum_b, 64'd5);
        chk("t2_sum_a", {56'd0, sum_a}, 64'd71);
        handshake();

        // Saturation in the 8-bit configuration, then cleared next batch.
        issue(89'd200); issue(89'd100); issue(89'd5); issue(89'd5);
        wait_ov("t3a");
        chk("t3_sum_a", {56'd0, sum_a}, 64'd255);
        chk("t3_sat_a", {63'd0, sat_a}, 64'd1);
        chk("t3_sum_b", sum_b, 64'd19);
        handshake();
        issue(89'd1); issue(89'd1); issue(89'd1); issue(89'd1);
        wait_ov("t3b");
        chk("t3b_sum_a", {56'd0, sum_a}, 64'd4);
        chk("t3b_sat_a", {63'd0, sat_a}, 64'd0);
        handshake();

        // Back-pressure while issuing continuously.
        issue_valid = 1'b1;
        for (int c = 0; c < 60 && !ov_a; c++) begin prod = rand_prod(); tick(); end
        wait_ov("t4a");
        for (int c = 0; c < 10; c++) begin
            prod = rand_prod();
            tick();
            chk("t4_mul_ce_stall", {63'd0, mul_ce_a}, 64'd0);
        end
        out_ready = 1'b1; prod = rand_prod(); tick(); out_ready = 1'b0;
        for (int c = 0; c < 60 && !ov_a; c++) begin prod = rand_prod(); tick(); end
        issue_valid = 1'b0;
        wait_ov("t4b");
        handshake();

        // ce toggling; out_ready only offered while ce is low.
        pulse_reset();
        idx = 0;
        for (int c = 0; c < 80 && !ov_a; c++) begin
            ce          = (c % 2 == 0);
            issue_valid = ce && (idx < 4);
            prod        = (idx < 4) ? t5[idx] : rand_prod();
            out_ready   = !ce;
            tick();
            if (issue_valid) idx++;
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ce = (c % 2 == 1); out_ready = !ce; tick();
        end
        ce = 1'b1; out_ready = 1'b0;
        wait_ov("t5");
        chk("t5_sum_a", {56'd0, sum_a}, 64'd30);
        chk("t5_sum_b", sum_b, 64'd2);
        handshake();

        // Reset mid-batch discards partial work.
        pulse_reset();
        issue(89'd5); issue(89'd5);
        tick();
        pulse_reset();
        issue(89'd7); issue(89'd7); issue(89'd7); issue(89'd7);
        wait_ov("t6");
        chk("t6_sum_a", {56'd0, sum_a}, 64'd28);
        chk("t6_sum_b", sum_b, 64'd0);
        handshake();

        // Random traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom % 200 == 0);
            ce          = ($urandom % 5 != 0);
            issue_valid = ($urandom % 4 != 0);
            out_ready   = ($urandom % 2 == 0);
            prod        = rand_prod();
            tick();
        end
        reset = 1'b0; ce = 1'b1; issue_valid = 1'b0; out_ready = 1'b1;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
